// File: rtl/aes_tbox_lookup.sv
// aes_tbox_lookup: two-stage AES Te/Td T-table lookup, LANES bytes per request; AES_TBOX_LASTROUND_EN adds S-box-only last-round words.
// Latency 2 cycles, 1 req/cycle; a stalled result (out_valid && !out_ready) freezes both stages and drops in_ready.
module aes_tbox_lookup #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_decrypt,
  input  logic                  in_last,
  input  logic [2*LANES-1:0]    in_rot,
  input  logic [8*LANES-1:0]    in_bytes,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_words,
  output logic [31:0]           out_xor,
  output logic [TAG_W-1:0]      out_tag
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] a, input logic dec);
    return dec ? sbox_inv(a) : sbox_fwd(a);
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] w, input logic [1:0] r);
    case (r)
      2'd1:    return {w[7:0],  w[31:8]};
      2'd2:    return {w[15:0], w[31:16]};
      2'd3:    return {w[23:0], w[31:24]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] tword(input logic [7:0] a, input logic [1:0] r, input logic dec);
    logic [7:0]  s;
    logic [31:0] w;
    s = sub_byte(a, dec);
    if (dec) w = {gmul(s, 8'h0e), gmul(s, 8'h09), gmul(s, 8'h0d), gmul(s, 8'h0b)};
    else     w = {xtime(s), s, s, xtime(s) ^ s};
    return rotr32(w, r);
  endfunction

  logic                 advance;
  logic                 s1_valid;
  logic                 s1_decrypt;
  logic [2*LANES-1:0]   s1_rot;
  logic [8*LANES-1:0]   s1_bytes;
  logic [TAG_W-1:0]     s1_tag;
  logic [32*LANES-1:0]  lane_words;
  logic [31:0]          lane_xor;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifdef AES_TBOX_LASTROUND_EN
  logic s1_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     s1_last <= 1'b0;
    else if (advance) s1_last <= in_last;
  end
`else
  logic unused_last;
  assign unused_last = in_last;
`endif

  always_comb begin
    lane_words = '0;
    lane_xor   = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef AES_TBOX_LASTROUND_EN
      lane_words[32*i +: 32] = s1_last
          ? rotr32({24'h000000, sub_byte(s1_bytes[8*i +: 8], s1_decrypt)}, s1_rot[2*i +: 2])
          : tword(s1_bytes[8*i +: 8], s1_rot[2*i +: 2], s1_decrypt);
`else
      lane_words[32*i +: 32] = tword(s1_bytes[8*i +: 8], s1_rot[2*i +: 2], s1_decrypt);
`endif
    end
    for (int i = 0; i < LANES; i++) begin
      lane_xor = lane_xor ^ lane_words[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_decrypt <= 1'b0;
      s1_rot     <= '0;
      s1_bytes   <= '0;
      s1_tag     <= '0;
      out_valid  <= 1'b0;
      out_words  <= '0;
      out_xor    <= '0;
      out_tag    <= '0;
    end else if (advance) begin
      s1_valid   <= in_valid;
      s1_decrypt <= in_decrypt;
      s1_rot     <= in_rot;
      s1_bytes   <= in_bytes;
      s1_tag     <= in_tag;
      out_valid  <= s1_valid;
      out_words  <= lane_words;
      out_xor    <= lane_xor;
      out_tag    <= s1_tag;
    end
  end

endmodule

// File: tb/tb_aes_tbox_lookup.sv
// Bench for aes_tbox_lookup: directed vector table, ordered streaming with stalls,
// full byte/rotation/mode sweep against a table-based model, and mid-stream reset.
module tb_aes_tbox_lookup;
  localparam int LANES = 4;
  localparam int TAG_W = 4;
`ifdef AES_TBOX_LASTROUND_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic         in_last;
  logic [7:0]   in_rot;
  logic [31:0]  in_bytes;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_words;
  logic [31:0]  out_xor;
  logic [3:0]   out_tag;

  always #5 clk = ~clk;

  aes_tbox_lookup #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt), .in_last(in_last),
    .in_rot(in_rot), .in_bytes(in_bytes), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_words(out_words), .out_xor(out_xor), .out_tag(out_tag)
  );

  typedef struct {
    logic         dec;
    logic         last;
    logic [7:0]   rot;
    logic [31:0]  bytes;
    logic [127:0] words;
    logic [31:0]  xr;
  } vec_t;

  typedef struct {
    logic        dec;
    logic        last;
    logic [7:0]  rot;
    logic [31:0] bytes;
    logic [3:0]  tag;
  } req_t;

  typedef struct {
    logic [127:0] words;
    logic [31:0]  xr;
    logic [3:0]   tag;
  } rsp_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:255][7:0] sbox_tab;
  logic [7:0] sinv_tab [256];
  vec_t vecs [7];
  req_t req_q [$];
  rsp_t exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] model_word(input logic [7:0] a, input logic [1:0] r,
                                             input logic dec, input logic last);
    logic [7:0]  s;
    logic [31:0] w;
    int          sh;
    s = dec ? sinv_tab[a] : sbox_tab[a];
    if (LAST_EN && last) w = {24'h0, s};
    else if (dec)        w = {gm(s, 8'h0e), gm(s, 8'h09), gm(s, 8'h0d), gm(s, 8'h0b)};
    else                 w = {gm(s, 8'h02), s, s, gm(s, 8'h03)};
    sh = 8 * int'(r);
    return (w >> sh) | (w << (32 - sh));
  endfunction

  function automatic rsp_t model_req(input req_t q);
    rsp_t  p;
    logic [31:0] w;
    p.words = '0;
    p.xr    = '0;
    p.tag   = q.tag;
    for (int i = 0; i < LANES; i++) begin
      w = model_word(q.bytes[8*i +: 8], q.rot[2*i +: 2], q.dec, q.last);
      p.words[32*i +: 32] = w;
      p.xr = p.xr ^ w;
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input req_t q);
    in_decrypt = q.dec;
    in_last    = q.last;
    in_rot     = q.rot;
    in_bytes   = q.bytes;
    in_tag     = q.tag;
  endtask

  task automatic run_stream(input string name, input bit toggle);
    int   cyc   = 0;
    int   idx   = 0;
    int   got   = 0;
    int   total = req_q.size();
    bit   held  = 1'b0;
    logic [127:0] hw;
    logic [3:0]   ht;
    rsp_t e;
    exp_q.delete();
    while (got < total && cyc < 4000) begin
      out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (idx < total) begin
        drive_req(req_q[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check({name, "_in_ready"}, 128'(in_ready), 128'(!(out_valid && !out_ready)));
      if (held) check({name, "_hold"}, {out_valid, out_tag, out_words}, {1'b1, ht, hw});
      held = out_valid && !out_ready;
      hw   = out_words;
      ht   = out_tag;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({name, "_spurious"}, 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check({name, "_words"}, out_words, e.words);
          check({name, "_xor_tag"}, {out_xor, out_tag}, {e.xr, e.tag});
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_req(req_q[idx]));
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_count"}, 128'(got), 128'(total));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check({name, "_drain"}, 128'(out_valid), 128'(0));
    req_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t q;
    rsp_t e;
    sbox_tab = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int a = 0; a < 256; a++) sinv_tab[sbox_tab[a]] = a[7:0];

    vecs[0] = '{1'b0, 1'b0, 8'he4, 32'h00000000,
                128'h6363a5c6_63a5c663_a5c66363_c66363a5, 32'h63636363};
    vecs[1] = '{1'b1, 1'b0, 8'he4, 32'h00000000,
                128'hf4a75051_a75051f4_5051f4a7_51f4a750, 32'h52525252};
    vecs[2] = '{1'b1, 1'b0, 8'h55, 32'h63636363, 128'h0, 32'h00000000};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 32'h00000001,
                128'hc66363a5_c66363a5_c66363a5_f87c7c84, 32'h3e1f1f21};
    vecs[4] = '{1'b0, 1'b1, 8'he4, 32'h00000000,
                128'h6363a5c6_63a5c663_a5c66363_c66363a5, 32'h63636363};
    vecs[5] = '{1'b1, 1'b1, 8'he4, 32'h00000000,
                128'hf4a75051_a75051f4_5051f4a7_51f4a750, 32'h52525252};
    vecs[6] = '{1'b0, 1'b0, 8'he4, 32'h00000000,
                128'h6363a5c6_63a5c663_a5c66363_c66363a5, 32'h63636363};
    if (LAST_EN) begin
      vecs[4].words = 128'h00006300_00630000_63000000_00000063;
      vecs[5].words = 128'h00005200_00520000_52000000_00000052;
    end

    reset_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; in_last = 1'b0;
    in_rot = '0; in_bytes = '0; in_tag = '0; out_ready = 1'b1;
    #1;
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_outputs", {out_valid, out_tag, out_xor, out_words}, '0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_in_ready", 128'(in_ready), 128'(1));

    for (int v = 0; v < 7; v++) begin
      q = '{vecs[v].dec, vecs[v].last, vecs[v].rot, vecs[v].bytes, 4'(v + 3)};
      drive_req(q);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat1", v), 128'(out_valid), 128'(0));
      tick();
      check($sformatf("vec%0d_valid", v), 128'(out_valid), 128'(1));
      check($sformatf("vec%0d_words", v), out_words, vecs[v].words);
      check($sformatf("vec%0d_xor_tag", v), {out_xor, out_tag}, {vecs[v].xr, 4'(v + 3)});
    end
    tick();

    for (int i = 0; i < 16; i++) begin
      q = '{i[0], i[2], 8'($urandom), $urandom, 4'(i)};
      req_q.push_back(q);
    end
    run_stream("stream", 1'b1);

    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 4; r++)
        for (int g = 0; g < 64; g++) begin
          q.dec  = m[0];
          q.last = 1'b0;
          q.tag  = g[3:0];
          for (int i = 0; i < LANES; i++) begin
            q.bytes[8*i +: 8] = 8'(4 * g + i);
            q.rot[2*i +: 2]   = 2'(r + i);
          end
          req_q.push_back(q);
        end
    run_stream("sweep", 1'b0);

    out_ready = 1'b0;
    drive_req('{1'b0, 1'b0, 8'h1b, 32'h11223344, 4'ha});
    in_valid = 1'b1;
    tick();
    drive_req('{1'b1, 1'b0, 8'h6c, 32'h55667788, 4'hb});
    tick();
    in_valid = 1'b0;
    check("rst_full", {126'h0, out_valid, in_ready}, 128'h2);
    reset_n = 1'b0;
    #1;
    check("rst_flush", {out_valid, in_ready, out_tag, out_words}, {1'b0, 1'b1, 4'h0, 128'h0});
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    q = '{1'b1, 1'b0, 8'h93, 32'h0a0b0c0d, 4'h5};
    e = model_req(q);
    drive_req(q);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rst_no_stale", 128'(out_valid), 128'(0));
    tick();
    check("rst_new_valid_tag", {out_valid, out_tag}, {1'b1, 4'h5});
    check("rst_new_words", {out_xor, out_words}, {e.xr, e.words});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
